vga_timing_gen: RTL and testbench

//  Parametrised VGA/video timing generator; successor to the fixed 11-bit timing block.

---
 rtl/vga_timing_gen_if.sv | 49 ++++
 rtl/vga_timing_gen.sv | 133 +++++++++++++
 tb/tb_vga_timing_gen.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Video timing bus: shadowed timing config and control in, sync/coords/interrupts out.
interface vga_timing_gen_if #(
  parameter int unsigned CW = 12,
  parameter int unsigned FW = 8
);
  logic          i_ce;
  logic [CW-1:0] i_hSyncStart;
  logic [CW-1:0] i_hBpStart;
  logic [CW-1:0] i_hVisibleStart;
  logic [CW-1:0] i_hEnd;
  logic [CW-1:0] i_vSyncStart;
  logic [CW-1:0] i_vBpStart;
  logic [CW-1:0] i_vVisibleStart;
  logic [CW-1:0] i_vEnd;
  logic          i_hSyncPol;
  logic          i_vSyncPol;
  logic          i_cfgLoad;
  logic [CW-1:0] i_irqLine;
  logic          o_cfgPending;
  logic          o_hSync;
  logic          o_vSync;
  logic          o_visible;
  logic [CW-1:0] o_x;
  logic [CW-1:0] o_y;
  logic [CW-1:0] o_hcount;
  logic [CW-1:0] o_vcount;
  logic          o_inth;
  logic          o_intv;
  logic          o_intLine;
  logic [FW-1:0] o_frame;

  // Config/control side
  modport master (
    output i_ce, i_hSyncStart, i_hBpStart, i_hVisibleStart, i_hEnd,
           i_vSyncStart, i_vBpStart, i_vVisibleStart, i_vEnd,
           i_hSyncPol, i_vSyncPol, i_cfgLoad, i_irqLine,
    input  o_cfgPending, o_hSync, o_vSync, o_visible, o_x, o_y,
           o_hcount, o_vcount, o_inth, o_intv, o_intLine, o_frame
  );

  // Timing generator side
  modport slave (
    input  i_ce, i_hSyncStart, i_hBpStart, i_hVisibleStart, i_hEnd,
           i_vSyncStart, i_vBpStart, i_vVisibleStart, i_vEnd,
           i_hSyncPol, i_vSyncPol, i_cfgLoad, i_irqLine,
    output o_cfgPending, o_hSync, o_vSync, o_visible, o_x, o_y,
           o_hcount, o_vcount, o_inth, o_intv, o_intLine, o_frame
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator with shadowed timing registers that
// switch over only at frame wrap, pixel clock-enable and line interrupts.
module vga_timing_gen #(
  parameter int unsigned CW = 12,
  parameter int unsigned FW = 8
) (
  input  logic            i_clk,
  input  logic            i_reset,
  vga_timing_gen_if.slave bus
);

  // Raw counters and frame count
  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [FW-1:0] frame_q, frame_d;

  // Active (applied) timing registers
  logic [CW-1:0] hss_q, hbs_q, hvs_q, hend_q;
  logic [CW-1:0] vss_q, vbs_q, vvs_q, vend_q;
  logic          hpol_q, vpol_q;

  // Shadow load bookkeeping
  logic          pend_q, pend_d;
  logic          apply_c;

  // Registered timing outputs
  logic          hsync_q, hsync_d, vsync_q, vsync_d, vis_q, vis_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          inth_q, inth_d, intv_q, intv_d, intl_q, intl_d;

  logic          hs_raw_c, vs_raw_c, vis_c;

  // Next-state: counter advance, derived timing outputs and shadow apply
  always_comb begin
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    frame_d  = frame_q;
    pend_d   = pend_q | bus.i_cfgLoad;
    apply_c  = 1'b0;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    vis_d    = vis_q;
    x_d      = x_q;
    y_d      = y_q;
    inth_d   = 1'b0;
    intv_d   = 1'b0;
    intl_d   = 1'b0;
    hs_raw_c = (hcnt_q >= hss_q) && (hcnt_q < hbs_q);
    vs_raw_c = (vcnt_q >= vss_q) && (vcnt_q < vbs_q);
    vis_c    = (hcnt_q >= hvs_q) && (hcnt_q <= hend_q) &&
               (vcnt_q >= vvs_q) && (vcnt_q <= vend_q);
    if (bus.i_ce) begin
      hsync_d = hs_raw_c ^ ~hpol_q;
      vsync_d = vs_raw_c ^ ~vpol_q;
      vis_d   = vis_c;
      x_d     = vis_c ? (hcnt_q - hvs_q) : '0;
      y_d     = vis_c ? (vcnt_q - vvs_q) : '0;
      inth_d  = (hcnt_q == '0);
      intv_d  = (hcnt_q == '0) && (vcnt_q == '0);
      intl_d  = (hcnt_q == '0) && (vcnt_q == bus.i_irqLine);
      // '>=' keeps counters bounded even after an illegal config
      if (hcnt_q >= hend_q) begin
        hcnt_d = '0;
        if (vcnt_q >= vend_q) begin
          vcnt_d  = '0;
          frame_d = frame_q + FW'(1);
          apply_c = pend_d;
          if (pend_d) pend_d = 1'b0;
        end else begin
          vcnt_d = vcnt_q + CW'(1);
        end
      end else begin
        hcnt_d = hcnt_q + CW'(1);
      end
    end
  end

  // State and output registers; active config reloads on reset or frame-wrap apply
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      frame_q <= '0;
      pend_q  <= 1'b0;
      hsync_q <= ~bus.i_hSyncPol;
      vsync_q <= ~bus.i_vSyncPol;
      vis_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      inth_q  <= 1'b0;
      intv_q  <= 1'b0;
      intl_q  <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      frame_q <= frame_d;
      pend_q  <= pend_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      vis_q   <= vis_d;
      x_q     <= x_d;
      y_q     <= y_d;
      inth_q  <= inth_d;
      intv_q  <= intv_d;
      intl_q  <= intl_d;
    end
    if (i_reset || apply_c) begin
      hss_q  <= bus.i_hSyncStart;
      hbs_q  <= bus.i_hBpStart;
      hvs_q  <= bus.i_hVisibleStart;
      hend_q <= bus.i_hEnd;
      vss_q  <= bus.i_vSyncStart;
      vbs_q  <= bus.i_vBpStart;
      vvs_q  <= bus.i_vVisibleStart;
      vend_q <= bus.i_vEnd;
      hpol_q <= bus.i_hSyncPol;
      vpol_q <= bus.i_vSyncPol;
    end
  end

  assign bus.o_cfgPending = pend_q;
  assign bus.o_hSync      = hsync_q;
  assign bus.o_vSync      = vsync_q;
  assign bus.o_visible    = vis_q;
  assign bus.o_x          = x_q;
  assign bus.o_y          = y_q;
  assign bus.o_hcount     = hcnt_q;
  assign bus.o_vcount     = vcnt_q;
  assign bus.o_inth       = inth_q;
  assign bus.o_intv       = intv_q;
  assign bus.o_intLine    = intl_q;
  assign bus.o_frame      = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a frame-level reference model pushes the
// expected observation for every clock; a negedge monitor pops and compares.
module tb_vga_timing_gen;

  typedef struct {
    int hss, hbs, hvs, hend, vss, vbs, vvs, vend;
    bit hp, vp;
  } cfg_t;

  typedef struct packed {
    logic        hs, vs, vis;
    logic [11:0] x, y;
    logic        inth, intv, intl;
    logic [11:0] hc, vc;
    logic [7:0]  fr;
    logic        pend;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(12), .FW(8)) bus ();
  vga_timing_gen #(.CW(12), .FW(8)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   started = 1'b0;
  bit   done    = 1'b0;
  logic rst_seen = 1'b0;
  logic rst_hs = 1'b0, rst_vs = 1'b0;

  // Reference model state (driver only)
  cfg_t cur, act;
  int   h, v, fr, irq;
  bit   pend;
  obs_t last;

  // Remember what the reset edge should leave behind
  always @(posedge clk) begin
    rst_seen <= rst;
    rst_hs   <= ~bus.i_hSyncPol;
    rst_vs   <= ~bus.i_vSyncPol;
  end

  function automatic obs_t sample();
    obs_t o;
    o.hs = bus.o_hSync; o.vs = bus.o_vSync; o.vis = bus.o_visible;
    o.x = bus.o_x; o.y = bus.o_y;
    o.inth = bus.o_inth; o.intv = bus.o_intv; o.intl = bus.o_intLine;
    o.hc = bus.o_hcount; o.vc = bus.o_vcount; o.fr = bus.o_frame;
    o.pend = bus.o_cfgPending;
    return o;
  endfunction

  // Monitor: every clock after the first edge presents one observation
  always @(negedge clk) begin
    if (started) begin
      obs_t a, e;
      a = sample();
      if (rst_seen) begin
        e = '0;
        e.hs = rst_hs;
        e.vs = rst_vs;
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL reset_state t=%0t got=%h exp=%h", $time, a, e);
        end
      end else if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underflow t=%0t got=%h", $time, a);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL obs t=%0t got=%h exp=%h", $time, a, e);
        end
      end
      if (done) begin
        total++;
        if (exp_q.size() != 0) begin
          bad++;
          $display("FAIL leftover got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  // Drive one clock of inputs and advance the reference model across that edge
  task automatic step(input bit ce, input bit ld, input bit r);
    obs_t e;
    bit   pn, hs, vs, vis;
    bus.i_hSyncStart = 12'(cur.hss);    bus.i_hBpStart = 12'(cur.hbs);
    bus.i_hVisibleStart = 12'(cur.hvs); bus.i_hEnd = 12'(cur.hend);
    bus.i_vSyncStart = 12'(cur.vss);    bus.i_vBpStart = 12'(cur.vbs);
    bus.i_vVisibleStart = 12'(cur.vvs); bus.i_vEnd = 12'(cur.vend);
    bus.i_hSyncPol = cur.hp; bus.i_vSyncPol = cur.vp;
    bus.i_irqLine = 12'(irq);
    bus.i_ce = ce; bus.i_cfgLoad = ld; rst = r;
    if (r) begin
      h = 0; v = 0; fr = 0; pend = 1'b0; act = cur;
      last = '0; last.hs = !cur.hp; last.vs = !cur.vp;
    end else begin
      e  = last;
      pn = pend | ld;
      e.inth = 1'b0; e.intv = 1'b0; e.intl = 1'b0;
      if (ce) begin
        hs  = (h >= act.hss) && (h < act.hbs);
        vs  = (v >= act.vss) && (v < act.vbs);
        vis = (h >= act.hvs) && (h <= act.hend) && (v >= act.vvs) && (v <= act.vend);
        e.hs = hs ? act.hp : !act.hp;
        e.vs = vs ? act.vp : !act.vp;
        e.vis = vis;
        e.x = vis ? 12'(h - act.hvs) : 12'd0;
        e.y = vis ? 12'(v - act.vvs) : 12'd0;
        e.inth = (h == 0);
        e.intv = (h == 0) && (v == 0);
        e.intl = (h == 0) && (v == irq);
        if (h >= act.hend) begin
          h = 0;
          if (v >= act.vend) begin
            v = 0;
            fr = (fr + 1) % 256;
            if (pn) begin act = cur; pn = 1'b0; end
          end else v = v + 1;
        end else h = h + 1;
      end
      pend = pn;
      e.hc = 12'(h); e.vc = 12'(v); e.fr = 8'(fr); e.pend = pend;
      exp_q.push_back(e);
      last = e;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       step(1'b1, 1'b0, 1'b0);
        1:       step(i % 2 == 0, 1'b0, 1'b0);
        default: step(($urandom % 4) != 0, ($urandom % 120) == 0, 1'b0);
      endcase
    end
  endtask

  initial begin
    cur = '{hss:2, hbs:4, hvs:6, hend:15, vss:1, vbs:2, vvs:3, vend:9, hp:1'b1, vp:1'b1};
    irq = 5;
    #1;
    started = 1'b1;
    // Baseline: 16-clock lines, 160-clock frames, active-high syncs
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    run(340, 0);
    // Inverted polarity
    cur.hp = 1'b0; cur.vp = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    run(170, 0);
    // Clock-enable stretching, then random enable
    cur.hp = 1'b1; cur.vp = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    run(400, 1);
    run(300, 2);
    // Mid-frame load of a wider line; a second strobe while pending picks up later inputs
    step(1'b0, 1'b0, 1'b1);
    run(50, 0);
    cur.hend = 31;
    step(1'b1, 1'b1, 1'b0);
    run(20, 0);
    cur.vend = 5;
    step(1'b1, 1'b1, 1'b0);
    run(700, 0);
    // Random configurations, loads, enables, irq lines and a mid-frame reset
    for (int r = 0; r < 6; r++) begin
      cur.hend = 8 + int'($urandom % 30);
      cur.hss  = int'($urandom % (cur.hend + 3));
      cur.hbs  = int'($urandom % (cur.hend + 3));
      cur.hvs  = int'($urandom % (cur.hend + 3));
      cur.vend = 3 + int'($urandom % 15);
      cur.vss  = int'($urandom % (cur.vend + 2));
      cur.vbs  = int'($urandom % (cur.vend + 2));
      cur.vvs  = int'($urandom % (cur.vend + 2));
      cur.hp   = 1'($urandom);
      cur.vp   = 1'($urandom);
      irq      = int'($urandom % (cur.vend + 2));
      if (r == 3) begin
        step(1'b1, 1'b0, 1'b1);
      end else begin
        step(1'b1, 1'b1, 1'b0);
      end
      run(450, 2);
    end
    done = 1'b1;
    repeat (3) @(posedge clk);
    $display("FAIL monitor_stalled");
    $fatal(1);
  end

endmodule
